// File: rtl/cache_pkg.sv
// Shared definitions for the cache, its CPU-side port arbiter and the pipeline.
// Holds the word-address geometry of the 4-set, 2-word-block cache and the
// arbiter state/owner types.
package cache_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned OFF_W  = 1;
    localparam int unsigned WORD_W = 32;

    // Word address layout: { tag[5:3], index[2:1], offset[0] }
    localparam int unsigned TAG_MSB = 5;
    localparam int unsigned TAG_LSB = 3;
    localparam int unsigned IDX_MSB = 2;
    localparam int unsigned IDX_LSB = 1;
    localparam int unsigned OFF_BIT = 0;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RD,
        ARB_WAIT_WR,
        ARB_RESP
    } arbState_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arbOwner_t;

    // Request captured at grant time; drives the cache port until RESP.
    typedef struct packed {
        arbOwner_t           owner;
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [WORD_W-1:0]   wdata;
    } arbLatch_t;

endpackage

// File: rtl/arb_grant_sel.sv
// Winner selection between the instruction and data requesters.
// Data wins by default; once MAX_D_STREAK consecutive data grants have been
// made while an instruction request was waiting, the instruction port wins.
// Ports:
//   clk, reset   - clock / synchronous active-high reset
//   i_req, d_req - raw request levels from the two requesters
//   grantEn      - arbiter is in IDLE and will latch the winner this cycle
//   grantValid   - at least one request is pending
//   grantOwner   - selected winner (meaningful only with grantValid)
module arb_grant_sel
    import cache_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_req,
    input  logic      d_req,
    input  logic      grantEn,
    output logic      grantValid,
    output arbOwner_t grantOwner
);

    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

    logic [STREAK_W-1:0] streak;
    logic                streakFull;

    assign streakFull = (streak == STREAK_W'(MAX_D_STREAK));

    always_comb begin
        grantValid = i_req | d_req;
        grantOwner = OWNER_I;
        if (d_req && !(i_req && streakFull)) begin
            grantOwner = OWNER_D;
        end
    end

    // Only data grants that overtake a waiting instruction request count
    // towards the streak; any instruction grant restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (grantEn && grantValid) begin
            if (grantOwner == OWNER_I) begin
                streak <= '0;
            end else if (i_req && !streakFull) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Arbitrates the single CPU-side cache port between instruction fetch
// (read-only) and the memory stage (read/write).
// Ports:
//   clk, reset                   - clock / synchronous active-high reset
//   i_req, i_addr                - instruction read request (held until i_ack)
//   i_ack, i_rdata               - one-cycle completion pulse and data
//   d_req, d_we, d_addr, d_wdata - data request (held until d_ack)
//   d_ack, d_rdata               - one-cycle completion pulse and data
//   c_read, c_write              - one-cycle cache request strobes
//   c_tag, c_index, c_offset     - latched address split for the cache
//   c_wdata                      - latched write data
//   c_rdata, c_hit               - cache read data and read-complete pulse
//   c_stall                      - cache refill status (informational only)
//   busy                         - arbiter not in IDLE
//   timeout_err                  - sticky flag, a read was abandoned
module cache_port_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned WRITE_CYCLES   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned MAX_D_STREAK   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [WORD_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [WORD_W-1:0] d_rdata,
    output logic              c_read,
    output logic              c_write,
    output logic [TAG_W-1:0]  c_tag,
    output logic [IDX_W-1:0]  c_index,
    output logic [OFF_W-1:0]  c_offset,
    output logic [WORD_W-1:0] c_wdata,
    input  logic [WORD_W-1:0] c_rdata,
    input  logic              c_hit,
    input  logic              c_stall,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > WRITE_CYCLES) ? TIMEOUT_CYCLES : WRITE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Counter value seen in the last wait cycle before moving to RESP.
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arbState_t        state;
    arbState_t        stateNext;
    arbLatch_t        lat;
    logic [CNT_W-1:0] cnt;

    logic             grantEn;
    logic             grantValid;
    arbOwner_t        grantOwner;

    logic             latchEn;
    logic             rdHit;
    logic             rdTimeout;
    logic             wrDone;
    logic [WORD_W-1:0] respData;

    // c_stall only reports refill activity; sequencing is driven by c_hit.
    logic             unusedStall;
    assign unusedStall = c_stall;

    arb_grant_sel #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_grantSel (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .d_req      (d_req),
        .grantEn    (grantEn),
        .grantValid (grantValid),
        .grantOwner (grantOwner)
    );

    assign grantEn = (state == ARB_IDLE);
    assign busy    = (state != ARB_IDLE);

    assign c_tag    = lat.addr[TAG_MSB:TAG_LSB];
    assign c_index  = lat.addr[IDX_MSB:IDX_LSB];
    assign c_offset = lat.addr[OFF_BIT];
    assign c_wdata  = lat.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        c_read    = 1'b0;
        c_write   = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        latchEn   = 1'b0;
        rdHit     = 1'b0;
        rdTimeout = 1'b0;
        wrDone    = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (grantValid) begin
                    latchEn   = 1'b1;
                    stateNext = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                c_read    = ~lat.we;
                c_write   = lat.we;
                stateNext = lat.we ? ARB_WAIT_WR : ARB_WAIT_RD;
            end
            ARB_WAIT_RD: begin
                // A hit in the final wait cycle still wins over the timeout.
                if (c_hit) begin
                    rdHit     = 1'b1;
                    stateNext = ARB_RESP;
                end else if (cnt == TO_LAST) begin
                    rdTimeout = 1'b1;
                    stateNext = ARB_RESP;
                end
            end
            ARB_WAIT_WR: begin
                if (cnt == WR_LAST) begin
                    wrDone    = 1'b1;
                    stateNext = ARB_RESP;
                end
            end
            ARB_RESP: begin
                i_ack     = (lat.owner == OWNER_I);
                d_ack     = (lat.owner == OWNER_D);
                stateNext = ARB_IDLE;
            end
            default: begin
                stateNext = ARB_IDLE;
            end
        endcase
    end

    assign respData = rdHit ? c_rdata : '0;

    // rdata registers load on the way into RESP so the data is valid
    // together with the ack and then simply holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat         <= '0;
            cnt         <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (latchEn) begin
                lat.owner <= grantOwner;
                if (grantOwner == OWNER_D) begin
                    lat.we    <= d_we;
                    lat.addr  <= d_addr;
                    lat.wdata <= d_wdata;
                end else begin
                    lat.we    <= 1'b0;
                    lat.addr  <= i_addr;
                    lat.wdata <= '0;
                end
            end

            if (state == ARB_ISSUE) begin
                cnt <= '0;
            end else if ((state == ARB_WAIT_RD) || (state == ARB_WAIT_WR)) begin
                cnt <= cnt + 1'b1;
            end

            if (rdHit || rdTimeout || wrDone) begin
                if (lat.owner == OWNER_I) begin
                    i_rdata <= respData;
                end else begin
                    d_rdata <= respData;
                end
            end

            if (rdTimeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: a behavioural cache responder
// plus a transaction-level expectation model (winner, latency, data).
module tb_cache_port_arbiter;
    import cache_pkg::*;

    localparam int unsigned WC = 3;
    localparam int unsigned TO = 8;
    localparam int unsigned MS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [5:0]  i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [5:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        c_read;
    logic        c_write;
    logic [2:0]  c_tag;
    logic [1:0]  c_index;
    logic [0:0]  c_offset;
    logic [31:0] c_wdata;
    logic [31:0] c_rdata;
    logic        c_hit;
    logic        c_stall;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    cache_port_arbiter #(
        .WRITE_CYCLES   (WC),
        .TIMEOUT_CYCLES (TO),
        .MAX_D_STREAK   (MS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_ack       (i_ack),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ack       (d_ack),
        .d_rdata     (d_rdata),
        .c_read      (c_read),
        .c_write     (c_write),
        .c_tag       (c_tag),
        .c_index     (c_index),
        .c_offset    (c_offset),
        .c_wdata     (c_wdata),
        .c_rdata     (c_rdata),
        .c_hit       (c_hit),
        .c_stall     (c_stall),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int unsigned nCmp = 0;
    int unsigned nBad = 0;

    // Cache behaviour: word store, hit a programmable number of cycles after
    // c_read (0 = never hit).
    logic [31:0] mem [64];
    int unsigned hitDelay = 1;
    int unsigned cd = 0;
    logic [5:0]  rdAddr = '0;

    // Expectation model state
    int unsigned mStreak = 0;
    bit          mTerr = 1'b0;
    logic [31:0] lastI = '0;
    logic [31:0] lastD = '0;
    logic [3:0]  winLog = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge, run the cache responder, check invariants.
    task automatic step();
        @(negedge clk);
        c_hit   = 1'b0;
        c_rdata = $urandom;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                c_hit   = 1'b1;
                c_rdata = mem[rdAddr];
            end
        end
        if (c_write) mem[{c_tag, c_index, c_offset}] = c_wdata;
        if (c_read) begin
            cd     = hitDelay;
            rdAddr = {c_tag, c_index, c_offset};
        end
        c_stall = (cd > 0);
        chk("strobe_excl", 32'(c_read & c_write), 32'd0);
        chk("ack_excl", 32'(i_ack & d_ack), 32'd0);
    endtask

    // Called in an IDLE cycle with the requests already applied.
    task automatic expectTxn(input string tag);
        bit          expD;
        bit          expWe;
        bit          isTo;
        bit          done;
        logic [5:0]  ea;
        logic [31:0] ew;
        logic [31:0] expData;
        int unsigned expLat;
        int unsigned n;

        expD = d_req && !(i_req && mStreak == MS);
        if (expD) begin
            if (i_req && mStreak < MS) mStreak++;
        end else begin
            mStreak = 0;
        end
        expWe = expD && d_we;
        ea    = expD ? d_addr : i_addr;
        ew    = d_wdata;
        isTo  = !expWe && !(hitDelay >= 1 && hitDelay <= TO);
        if (expWe)      expLat = 2 + WC;
        else if (isTo)  expLat = 2 + TO;
        else            expLat = 2 + hitDelay;

        step();
        chk({tag, "_c_read"}, 32'(c_read), 32'(!expWe));
        chk({tag, "_c_write"}, 32'(c_write), 32'(expWe));
        chk({tag, "_tag"}, 32'(c_tag), 32'(ea[5:3]));
        chk({tag, "_index"}, 32'(c_index), 32'(ea[2:1]));
        chk({tag, "_offset"}, 32'(c_offset), 32'(ea[0]));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        if (expWe) chk({tag, "_wdata"}, c_wdata, ew);
        expData = (expWe || isTo) ? 32'd0 : mem[ea];

        n    = 1;
        done = 1'b0;
        while (!done && n < 2 + TO + 6) begin
            // Requests are ignored outside IDLE, so payloads may wander.
            i_addr  = 6'($urandom);
            d_addr  = 6'($urandom);
            d_wdata = $urandom;
            d_we    = 1'($urandom_range(0, 1));
            step();
            n++;
            if (i_ack || d_ack) begin
                done = 1'b1;
            end else begin
                chk({tag, "_strobe_idle"}, 32'({c_read, c_write}), 32'd0);
                chk({tag, "_addr_stable"}, 32'({c_tag, c_index, c_offset}), 32'(ea));
                if (expWe) begin
                    chk({tag, "_wdata_stable"}, c_wdata, ew);
                    c_hit = 1'($urandom_range(0, 1));
                end
            end
        end
        chk({tag, "_ack_seen"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, n, expLat);
        chk({tag, "_ack_owner"}, 32'({i_ack, d_ack}), expD ? 32'd1 : 32'd2);
        if (expD) begin
            chk({tag, "_d_rdata"}, d_rdata, expData);
            chk({tag, "_i_rdata_hold"}, i_rdata, lastI);
            lastD = expData;
        end else begin
            chk({tag, "_i_rdata"}, i_rdata, expData);
            chk({tag, "_d_rdata_hold"}, d_rdata, lastD);
            lastI = expData;
        end
        if (isTo) mTerr = 1'b1;
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(mTerr));
        winLog = {winLog[2:0], d_ack};

        step();
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_ack"}, 32'({i_ack, d_ack}), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = $urandom;
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        c_rdata = '0;
        c_hit   = 1'b0;
        c_stall = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", 32'({c_read, c_write}), 32'd0);
        chk("rst_acks", 32'({i_ack, d_ack}), 32'd0);
        chk("rst_addr", 32'({c_tag, c_index, c_offset}), 32'd0);
        chk("rst_wdata", c_wdata, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        step();

        // Instruction read, hit 3 cycles after c_read
        mem[6'b101101] = 32'h1234_5678;
        hitDelay = 3;
        i_req    = 1'b1;
        i_addr   = 6'b101101;
        expectTxn("ird");
        chk("ird_data", i_rdata, 32'h1234_5678);
        i_req = 1'b0;

        // Simultaneous requests: data first, instruction right after
        i_req  = 1'b1;
        i_addr = 6'($urandom);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 6'($urandom);
        hitDelay = 2;
        expectTxn("sim_d");
        d_req = 1'b0;
        expectTxn("sim_i");
        chk("sim_order", 32'(winLog[1:0]), 32'b10);

        // Starvation guard: both held continuously
        i_req = 1'b1;
        d_req = 1'b1;
        hitDelay = 1;
        for (int k = 0; k < 4; k++) expectTxn("starve");
        chk("starve_order", 32'(winLog), 32'b1101);
        i_req = 1'b0;
        d_req = 1'b0;
        step();

        // Write
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 6'b010011;
        d_wdata = 32'hCAFE_F00D;
        expectTxn("wr");
        chk("wr_rdata", d_rdata, 32'd0);
        chk("wr_mem", mem[6'b010011], 32'hCAFE_F00D);
        d_req = 1'b0;

        // Read timeout, then sticky error across a normal read
        hitDelay = 0;
        i_req    = 1'b1;
        i_addr   = 6'($urandom);
        expectTxn("to");
        chk("to_rdata", i_rdata, 32'd0);
        chk("to_err", 32'(timeout_err), 32'd1);
        hitDelay = TO;
        expectTxn("to_edge_hit");
        i_req = 1'b0;
        step();
        chk("to_sticky", 32'(timeout_err), 32'd1);

        // Randomized transactions
        for (int k = 0; k < 40; k++) begin
            i_req   = 1'($urandom_range(0, 1));
            d_req   = 1'($urandom_range(0, 1));
            if (!i_req && !d_req) d_req = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            i_addr  = 6'($urandom);
            d_addr  = 6'($urandom);
            d_wdata = $urandom;
            hitDelay = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO);
            expectTxn("rnd");
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();

        // Reset while waiting on a read
        hitDelay = 0;
        i_req    = 1'b1;
        i_addr   = 6'b111111;
        step();
        i_req = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_acks", 32'({i_ack, d_ack}), 32'd0);
        chk("mid_rst_strobes", 32'({c_read, c_write}), 32'd0);
        chk("mid_rst_addr", 32'({c_tag, c_index, c_offset}), 32'd0);
        chk("mid_rst_rdata", i_rdata | d_rdata | c_wdata, 32'd0);
        chk("mid_rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        mStreak = 0;
        mTerr   = 1'b0;
        lastI   = '0;
        lastD   = '0;
        cd      = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_no_ack", 32'({i_ack, d_ack, busy}), 32'd0);
        end
        hitDelay = 2;
        i_req    = 1'b1;
        i_addr   = 6'($urandom);
        expectTxn("post_rst");
        i_req = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
Arbitrates the single CPU-side port of the 4-set, 2-word-block data/instruction cache between two requesters: the instruction-fetch stage (read-only) and the memory stage (read/write).
- Latches one winning request, splits its 6-bit word address into tag/index/offset, and drives the cache's read/write request strobes.
- Waits for the cache's hit pulse (reads) or a fixed write-completion window (writes), then returns a one-cycle ack with data to the winner.
- Sits between the pipeline stages and the cache; main-memory traffic stays behind the cache.

Parameters:
WRITE_CYCLES, 3, cycles from write issue to ack (covers cache WRITE, UPDATE and return-to-IDLE).
TIMEOUT_CYCLES, 64, max cycles waiting for c_hit before abandoning a read.
MAX_D_STREAK, 4, consecutive data grants allowed while an instruction request waits.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
i_req  in  1  instruction read request, held until i_ack.
i_addr  in  6  instruction word address.
i_ack  out  1  one-cycle completion pulse to instruction port.
i_rdata  out  32  instruction word, valid while i_ack=1.
d_req  in  1  data request, held until d_ack.
d_we  in  1  1=write, 0=read.
d_addr  in  6  data word address.
d_wdata  in  32  write data.
d_ack  out  1  one-cycle completion pulse to data port.
d_rdata  out  32  read data, valid while d_ack=1.
c_read  out  1  cache read request (one-cycle pulse).
c_write  out  1  cache write request (one-cycle pulse).
c_tag  out  3  equals latched addr[5:3].
c_index  out  2  equals latched addr[2:1].
c_offset  out  1  equals latched addr[0].
c_wdata  out  32  latched write data.
c_rdata  in  32  cache read data, valid with c_hit.
c_hit  in  1  cache read-complete pulse.
c_stall  in  1  cache miss/refill in progress (status only; does not change sequencing).
busy  out  1  1 in any state except IDLE.
timeout_err  out  1  sticky; set on read timeout.

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-transaction): state=IDLE. All outputs=0, latches=0, streak and timeout counters=0, timeout_err=0. A transaction in flight is dropped and no ack is issued.
- States: IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP.
- IDLE:
  - If any request is pending, select a winner and latch owner, we, addr and wdata; go to ISSUE.
  - Priority is data over instruction, except when both are requesting and streak==MAX_D_STREAK, in which case instruction wins.
  - streak increments on a data grant made while i_req=1 (saturating at MAX_D_STREAK). It clears on any instruction grant.
  - An instruction grant always has we=0.
- ISSUE: c_read=1 (if we=0) or c_write=1 (if we=1) for exactly this cycle. Next state is WAIT_RD or WAIT_WR.
- c_tag, c_index, c_offset and c_wdata come from the latch and stay stable from ISSUE through RESP.
- WAIT_RD:
  - Timeout counter increments each cycle.
  - On c_hit=1, capture c_rdata and go to RESP.
  - If the count reaches TIMEOUT_CYCLES without c_hit, set timeout_err, set captured data=0, and go to RESP.
- WAIT_WR: counter runs from 1 to WRITE_CYCLES, then go to RESP. c_hit is ignored here.
- RESP:
  - The owner's ack=1 for this cycle, with its rdata equal to the captured data (0 for writes).
  - The non-owner's ack stays 0. Go to IDLE.
  - rdata outputs hold their last value otherwise.
- Handshake:
  - Requesters sample ack at the rising edge. Requests are ignored in every state except IDLE.
  - A requester wanting back-to-back transactions keeps req high; the next grant can occur in the IDLE cycle after RESP.
- Min latency (request seen in IDLE at cycle 0):
  - Read: c_read at cycle 1, ack 1 cycle after c_hit.
  - Write: c_write at cycle 1, ack at cycle 2+WRITE_CYCLES.
- c_read and c_write are never high in the same cycle, and never high outside ISSUE.
- Both acks are never high in the same cycle.

Decomposition:
- Shared package (cache_pkg): ADDR_W=6, TAG_W=3, IDX_W=2, WORD_W=32, address slice constants, arbiter state enum. It is shared with the cache and the pipeline.
- One natural sub-module, arb_grant_sel: combinational winner select plus registered streak counter.

Test Plan:
- Instruction read: i_req, i_addr=6'b101_10_1; model hits 3 cycles after c_read with c_rdata=32'h1234_5678 -> c_tag=5, c_index=2, c_offset=1; c_read at cycle 1; i_ack at cycle 5 with i_rdata=32'h1234_5678.
- Simultaneous: i_req and d_req (read) at cycle 0 -> d_ack first; then instruction issued in the IDLE cycle after d RESP; i_ack follows.
- Starvation, MAX_D_STREAK=2: d_req held continuously with i_req high -> grants in order d, d, i, d.
- Write, WRITE_CYCLES=3: d_we=1, d_wdata=32'hCAFE_F00D -> c_write pulses exactly 1 cycle; c_wdata stable; d_ack at cycle 5, d_rdata=0.
- Timeout, TIMEOUT_CYCLES=8: cache never hits -> i_ack after 8 wait cycles with i_rdata=0; timeout_err=1 and stays 1 until reset.
- Reset asserted during WAIT_RD -> next cycle busy=0, all outputs 0, no ack; a fresh request after reset completes normally.
